alu_pipe: RTL and testbench

//  Parametrised, pipelined successor of the combinational 16-bit six-control-bit ALU.

---
 rtl/alu_pipe.sv | 115 +++++++++++
 tb/tb_alu_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with zx/nx/zy/ny/f/no control, carry/overflow flags,
// valid/ready handshakes on both sides, tag passthrough and a wrapping op counter.
module alu_pipe #(
   parameter int WIDTH   = 16,
   parameter int TAG_W   = 4,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic [5:0]         ctl,
   input  logic [TAG_W-1:0]   tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic [TAG_W-1:0]   out_tag,
   output logic               zr,
   output logic               ng,
   output logic               cy,
   output logic               ov,
   output logic [COUNT_W-1:0] op_count
);

   logic               run;
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_x;
   logic [WIDTH-1:0]   s1_y;
   logic               s1_f;
   logic               s1_no;
   logic [TAG_W-1:0]   s1_tag;
   logic               s2_load;
   logic [WIDTH-1:0]   x_z;
   logic [WIDTH-1:0]   y_z;
   logic [WIDTH-1:0]   x_pre;
   logic [WIDTH-1:0]   y_pre;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   pre_res;
   logic [WIDTH-1:0]   res;
   logic               carry;
   logic               ovf;

   assign x_z   = ctl[5] ? '0 : x;
   assign x_pre = ctl[4] ? ~x_z : x_z;
   assign y_z   = ctl[3] ? '0 : y;
   assign y_pre = ctl[2] ? ~y_z : y_z;

   assign sum     = {1'b0, s1_x} + {1'b0, s1_y};
   assign carry   = s1_f & sum[WIDTH];
   assign ovf     = s1_f & (s1_x[WIDTH-1] == s1_y[WIDTH-1]) & (sum[WIDTH-1] != s1_x[WIDTH-1]);
   assign pre_res = s1_f ? sum[WIDTH-1:0] : (s1_x & s1_y);
   assign res     = s1_no ? ~pre_res : pre_res;

   // run keeps in_ready low until the first edge after reset release
   assign s2_load  = s1_valid & (~out_valid | out_ready);
   assign in_ready = run & (~s1_valid | s2_load);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_f     <= 1'b0;
         s1_no    <= 1'b0;
         s1_tag   <= '0;
      end else begin
         run <= 1'b1;
         if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_x   <= x_pre;
               s1_y   <= y_pre;
               s1_f   <= ctl[1];
               s1_no  <= ctl[0];
               s1_tag <= tag;
            end
         end
      end
   end

   // Output register holds its contents whenever it is not reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_tag   <= '0;
         zr        <= 1'b0;
         ng        <= 1'b0;
         cy        <= 1'b0;
         ov        <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out       <= res;
         out_tag   <= s1_tag;
         zr        <= (res == '0);
         ng        <= res[WIDTH-1];
         cy        <= carry;
         ov        <= ovf;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (out_valid & out_ready) begin
         op_count <= op_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against
// an arithmetic reference model and an in-order scoreboard queue.
module tb_alu_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [5:0]  ctl;
   logic [3:0]  tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out;
   logic [3:0]  out_tag;
   logic        zr;
   logic        ng;
   logic        cy;
   logic        ov;
   logic [3:0]  op_count;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flags;
      logic [3:0]  tag;
      int          acc_edge;
   } exp_t;

   exp_t       q[$];
   logic [3:0] cnt;
   int         edge_cnt;
   int         checks;
   int         errors;

   alu_pipe #(.WIDTH(16), .TAG_W(4), .COUNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .ctl       (ctl),
      .tag       (tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_tag   (out_tag),
      .zr        (zr),
      .ng        (ng),
      .cy        (cy),
      .ov        (ov),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU in plain integer arithmetic; flags packed as {zr,ng,cy,ov}
   function automatic exp_t refModel(logic [15:0] xv, logic [15:0] yv, logic [5:0] c, logic [3:0] t);
      exp_t e;
      int   xa, ya, s, sx, sy, ss, r;
      logic fc, fo;
      xa = c[5] ? 0 : int'(xv);
      if (c[4]) xa = 65535 - xa;
      ya = c[3] ? 0 : int'(yv);
      if (c[2]) ya = 65535 - ya;
      if (c[1]) begin
         s  = xa + ya;
         r  = s % 65536;
         fc = (s > 65535);
         sx = (xa >= 32768) ? xa - 65536 : xa;
         sy = (ya >= 32768) ? ya - 65536 : ya;
         ss = sx + sy;
         fo = (ss > 32767) || (ss < -32768);
      end else begin
         r  = xa & ya;
         fc = 1'b0;
         fo = 1'b0;
      end
      if (c[0]) r = 65535 - r;
      e.res      = r[15:0];
      e.flags    = {(r == 0), (r >= 32768), fc, fo};
      e.tag      = t;
      e.acc_edge = 0;
      return e;
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      assert (actual === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(bit v, logic [15:0] xv, logic [15:0] yv, logic [5:0] c,
                                logic [3:0] t, bit r);
      in_valid  = v;
      x         = xv;
      y         = yv;
      ctl       = c;
      tag       = t;
      out_ready = r;
   endtask

   // One clock cycle: check outputs against the model, then update it for this edge
   task automatic tick(output bit acc, output bit ho);
      bit   exp_ready;
      bit   exp_ov;
      exp_t e;
      #1;
      exp_ready = (q.size() < 2) || out_ready;
      exp_ov    = (q.size() > 0) && (edge_cnt > q[0].acc_edge);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("out_valid", out_valid, exp_ov);
      checkOutput("op_count", op_count, cnt);
      if (exp_ov) begin
         checkOutput("out", out, q[0].res);
         checkOutput("out_tag", out_tag, q[0].tag);
         checkOutput("flags", {zr, ng, cy, ov}, q[0].flags);
      end
      ho  = exp_ov && out_ready;
      acc = in_valid && exp_ready;
      if (ho) begin
         void'(q.pop_front());
         cnt = cnt + 4'd1;
      end
      if (acc) begin
         e          = refModel(x, y, ctl, tag);
         e.acc_edge = edge_cnt + 1;
         q.push_back(e);
      end
      @(posedge clk);
      edge_cnt++;
      #1;
   endtask

   task automatic resetDut();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_op_count", op_count, 0);
      checkOutput("rst_out", out, 0);
      q.delete();
      cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      edge_cnt++;
      #1;
      checkOutput("rst_in_ready", in_ready, 1);
   endtask

   task automatic directedOp(logic [15:0] xv, logic [15:0] yv, logic [5:0] c,
                             logic [15:0] eo, logic [3:0] ef);
      bit a, h;
      applyStimulus(1'b1, xv, yv, c, 4'hA, 1'b1);
      tick(a, h);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
      tick(a, h);
      checkOutput("dir_valid", out_valid, 1);
      checkOutput("dir_out", out, eo);
      checkOutput("dir_flags", {zr, ng, cy, ov}, ef);
      tick(a, h);
   endtask

   initial begin
      bit a, h;
      int issued;
      int hcount;
      checks   = 0;
      errors   = 0;
      edge_cnt = 0;
      cnt      = '0;
      rst_n    = 1'b0;
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
      #2;
      checkOutput("init_out_valid", out_valid, 0);
      checkOutput("init_op_count", op_count, 0);
      checkOutput("init_out", {out_tag, zr, ng, cy, ov, out}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      edge_cnt++;
      #1;
      checkOutput("init_in_ready", in_ready, 1);

      $display("[TB] directed ALU cases");
      directedOp(16'h1234, 16'h5678, 6'b101010, 16'h0000, 4'b1000);
      directedOp(16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 4'b0101);
      directedOp(16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 4'b1010);
      directedOp(16'h0005, 16'h0007, 6'b010011, 16'hFFFE, 4'b0110);

      $display("[TB] backpressure with six tagged ops");
      resetDut();
      issued = 0;
      for (int c = 1; c <= 14; c++) begin
         applyStimulus(issued < 6, 16'($urandom), 16'($urandom), 6'($urandom), 4'(issued),
                       !(c >= 3 && c <= 6));
         tick(a, h);
         if (a) issued++;
      end
      checkOutput("t4_op_count", op_count, 6);
      checkOutput("t4_idle", out_valid, 0);

      $display("[TB] op_count wrap");
      resetDut();
      issued = 0;
      hcount = 0;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(issued < 17, 16'($urandom), 16'($urandom), 6'($urandom), 4'($urandom), 1'b1);
         tick(a, h);
         if (a) issued++;
         if (h) begin
            hcount++;
            if (hcount == 15) checkOutput("wrap_15", op_count, 15);
            if (hcount == 16) checkOutput("wrap_16", op_count, 0);
         end
      end
      checkOutput("wrap_17", op_count, 1);

      $display("[TB] reset with full pipeline");
      applyStimulus(1'b1, 16'h1111, 16'h2222, 6'b000010, 4'h1, 1'b0);
      tick(a, h);
      applyStimulus(1'b1, 16'h3333, 16'h4444, 6'b000010, 4'h2, 1'b0);
      tick(a, h);
      applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
      tick(a, h);
      #3;
      resetDut();
      directedOp(16'h0005, 16'h0007, 6'b010011, 16'hFFFE, 4'b0110);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 300; c++) begin
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 6'($urandom),
                       4'($urandom), $urandom_range(0, 3) != 0);
         tick(a, h);
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, '0, '0, '0, '0, 1'b1);
         tick(a, h);
      end
      checkOutput("drain_idle", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
